ps2_mouse_rx: RTL and testbench

PS/2 mouse line interface for the mouse path. It decodes the raw PS/2 clock/data lines from a physical mouse and builds the 25-bit packet word (`ps2_mouse`) that the MSX-protocol mouse stage consumes. After reset it can send the stream-enable command 0xF4 to the mouse. Each complete 3-byte movement packet is published with a toggle bit, so the downstream stage can detect new packets by edge.

---
 rtl/ps2_mouse_rx_if.sv | 20 ++
 rtl/ps2_mouse_rx.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_mouse_rx.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_rx_if.sv
// PS/2 line pins and packet-side outputs of ps2_mouse_rx.
// slave = the receiver block, master = the bench / board side.
interface ps2_mouse_rx_if;
  logic        ps2_clk_i;
  logic        ps2_data_i;
  logic        ps2_clk_oe;
  logic        ps2_data_oe;
  logic [24:0] ps2_mouse;
  logic        frame_err;
  logic        init_done;

  modport master (
    output ps2_clk_i, ps2_data_i,
    input  ps2_clk_oe, ps2_data_oe, ps2_mouse, frame_err, init_done
  );
  modport slave (
    input  ps2_clk_i, ps2_data_i,
    output ps2_clk_oe, ps2_data_oe, ps2_mouse, frame_err, init_done
  );
endinterface

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: line conditioning, optional 0xF4 stream-enable handshake,
// 3-byte packet assembly published as a 25-bit word with a per-packet toggle bit.
module ps2_mouse_rx #(
  parameter int FILTER      = 8,
  parameter int INHIBIT_CYC = 2400,
  parameter int TIMEOUT_CYC = 40000,
  parameter bit SEND_INIT   = 1'b1
) (
  input logic           clk,
  input logic           reset_n,
  ps2_mouse_rx_if.slave bus
);
  localparam int FW = $clog2(FILTER + 1);
  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] CMD = 8'hF4;

  typedef enum logic [2:0] {S_INHIBIT, S_REQ, S_TX, S_TXACK, S_WAIT_FA, S_RUN} state_t;
  localparam state_t S_RST = SEND_INIT ? S_INHIBIT : S_RUN;

  // lane 0 = clock, lane 1 = data
  logic [1:0]         sy1, sy2, filt, flip;
  logic [1:0][FW-1:0] fcnt;

  always_comb begin
    flip = '0;
    for (int i = 0; i < 2; i++)
      flip[i] = (sy2[i] != filt[i]) && (fcnt[i] == FW'(FILTER - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sy1  <= '1;
      sy2  <= '1;
      filt <= '1;
      fcnt <= '0;
    end else begin
      sy1 <= {bus.ps2_data_i, bus.ps2_clk_i};
      sy2 <= sy1;
      for (int i = 0; i < 2; i++) begin
        if ((sy2[i] == filt[i]) || flip[i]) fcnt[i] <= '0;
        else                                fcnt[i] <= fcnt[i] + 1'b1;
        if (flip[i]) filt[i] <= sy2[i];
      end
    end
  end

  logic bit_ev, din;
  assign bit_ev = filt[0] & flip[0];
  assign din    = filt[1];

  state_t        state_q, state_d;
  logic [IW-1:0] inh_cnt;
  logic [3:0]    tx_n;
  logic          clk_oe_q, data_oe_q, data_oe_d, init_q;

  // gap timer: cycles since the last bit event
  logic [TW-1:0] gap;
  logic          tmo, hold_gap;
  assign hold_gap = (state_q == S_INHIBIT) || (state_q == S_REQ);
  assign tmo      = !bit_ev && (gap == TW'(TIMEOUT_CYC - 1));

  logic       rx_en, in_frame, par, byte_end, byte_ok;
  logic [3:0] rx_n;
  logic [7:0] sr, b0, b1;
  logic [1:0] idx;
  logic [24:0] mouse_q;
  logic        err_q;

  assign rx_en    = (state_q == S_WAIT_FA) || (state_q == S_RUN);
  assign byte_end = rx_en && bit_ev && in_frame && (rx_n == 4'd9);
  assign byte_ok  = byte_end && din && (^{sr, par});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) gap <= '0;
    else if (bit_ev || tmo || hold_gap) gap <= '0;
    else gap <= gap + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_frame <= 1'b0;
      rx_n     <= '0;
      sr       <= '0;
      par      <= 1'b0;
      idx      <= '0;
      b0       <= '0;
      b1       <= '0;
      mouse_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (!rx_en) begin
        in_frame <= 1'b0;
        rx_n     <= '0;
      end else if (bit_ev) begin
        if (!in_frame) begin
          if (!din) begin
            in_frame <= 1'b1;
            rx_n     <= '0;
          end
        end else if (rx_n < 4'd8) begin
          sr   <= {din, sr[7:1]};
          rx_n <= rx_n + 4'd1;
        end else if (rx_n == 4'd8) begin
          par  <= din;
          rx_n <= 4'd9;
        end else begin
          in_frame <= 1'b0;
          if (!byte_ok) begin
            err_q <= 1'b1;
            idx   <= '0;
          end else if (state_q == S_RUN) begin
            // status byte must carry its always-one bit 3, else we are out of sync
            case (idx)
              2'd0: begin
                if (sr[3]) begin
                  b0  <= sr;
                  idx <= 2'd1;
                end else err_q <= 1'b1;
              end
              2'd1: begin
                b1  <= sr;
                idx <= 2'd2;
              end
              default: begin
                mouse_q <= {~mouse_q[24], sr, b1, b0};
                idx     <= '0;
              end
            endcase
          end
        end
      end else if (tmo) begin
        if (in_frame) begin
          in_frame <= 1'b0;
          err_q    <= 1'b1;
        end
        idx <= '0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    data_oe_d = data_oe_q;
    case (state_q)
      S_INHIBIT: begin
        data_oe_d = 1'b0;
        if (inh_cnt == IW'(INHIBIT_CYC - 1)) begin
          state_d   = S_REQ;
          data_oe_d = 1'b1;
        end
      end
      S_REQ: state_d = S_TX;
      S_TX: begin
        if (tmo) begin
          state_d   = S_INHIBIT;
          data_oe_d = 1'b0;
        end else if (bit_ev) begin
          if (tx_n < 4'd8)       data_oe_d = ~CMD[tx_n[2:0]];
          else if (tx_n == 4'd8) data_oe_d = ^CMD;
          else begin
            data_oe_d = 1'b0;
            state_d   = S_TXACK;
          end
        end
      end
      S_TXACK: begin
        if (tmo)         state_d = S_INHIBIT;
        else if (bit_ev) state_d = din ? S_INHIBIT : S_WAIT_FA;
      end
      S_WAIT_FA: begin
        if (byte_ok && (sr == 8'hFA)) state_d = S_RUN;
        else if (tmo)                 state_d = S_INHIBIT;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_RST;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      init_q    <= 1'b0;
      inh_cnt   <= '0;
      tx_n      <= '0;
    end else begin
      state_q   <= state_d;
      data_oe_q <= data_oe_d;
      clk_oe_q  <= (state_d == S_INHIBIT) || (state_d == S_REQ);
      init_q    <= (state_d == S_RUN);
      inh_cnt   <= (state_q == S_INHIBIT) ? inh_cnt + 1'b1 : '0;
      tx_n      <= (state_q != S_TX) ? 4'd0 : tx_n + {3'd0, bit_ev};
    end
  end

  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;
  assign bus.ps2_mouse   = mouse_q;
  assign bus.frame_err   = err_q;
  assign bus.init_done   = init_q;
endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx: u0 runs without init (packet checks vs. a byte-level model),
// u1 runs the 0xF4/0xFA handshake against a device model.
module tb_ps2_mouse_rx;
  localparam int HB  = 20;
  localparam int TMO = 40000;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic d_clk [2] = '{1'b1, 1'b1};
  logic d_dat [2] = '{1'b1, 1'b1};

  ps2_mouse_rx_if if0 ();
  ps2_mouse_rx_if if1 ();

  assign if0.ps2_clk_i  = d_clk[0] & ~if0.ps2_clk_oe;
  assign if0.ps2_data_i = d_dat[0] & ~if0.ps2_data_oe;
  assign if1.ps2_clk_i  = d_clk[1] & ~if1.ps2_clk_oe;
  assign if1.ps2_data_i = d_dat[1] & ~if1.ps2_data_oe;

  ps2_mouse_rx #(.SEND_INIT(1'b0)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  ps2_mouse_rx #(.SEND_INIT(1'b1)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // byte-level packet model
  logic [24:0] exp_q [$];
  int          m_idx   = 0;
  logic        m_tog   = 1'b0;
  logic [7:0]  m_b0, m_b1;
  int          exp_err = 0;
  int          got_err = 0;

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_err++;
      m_idx = 0;
    end else if (m_idx == 0) begin
      if (b[3]) begin m_b0 = b; m_idx = 1; end
      else exp_err++;
    end else if (m_idx == 1) begin
      m_b1 = b;
      m_idx = 2;
    end else begin
      m_tog = ~m_tog;
      exp_q.push_back({m_tog, b, m_b1, m_b0});
      m_idx = 0;
    end
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop
  task automatic send_frame(input int ch, input logic [7:0] b, input int kind,
                            input int nbits, input bit mdl);
    logic [10:0] f;
    f = {(kind != 2), ((~^b) ^ (kind == 1)), b, 1'b0};
    if (mdl) model_byte(b, kind == 0);
    for (int i = 0; i < nbits; i++) begin
      d_dat[ch] = f[i];
      repeat (HB) @(negedge clk);
      d_clk[ch] = 1'b0;
      repeat (HB) @(negedge clk);
      d_clk[ch] = 1'b1;
    end
    d_dat[ch] = 1'b1;
    repeat (2 * HB) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_frame(0, a, 0, 11, 1);
    send_frame(0, b, 0, 11, 1);
    send_frame(0, c, 0, 11, 1);
  endtask

  task automatic checkpoint(input string nm);
    repeat (20) @(negedge clk);
    chk({nm, "_pending"}, exp_q.size(), 0);
    chk({nm, "_err_count"}, got_err, exp_err);
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    #1 reset_n = 1'b0;
    m_idx = 0;
    m_tog = 1'b0;
    exp_q.delete();
    repeat (n) @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  // per-cycle compare of u0 against the model
  logic [24:0] last0 = '0;
  logic        prev_err = 1'b0;
  int          since = 0;
  initial begin : cmp
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        since = 0;
        last0 = '0;
        prev_err = 1'b0;
        chk("rst_u0", {if0.ps2_mouse, if0.ps2_clk_oe, if0.ps2_data_oe, if0.frame_err, if0.init_done}, 0);
        chk("rst_u1", {if1.ps2_mouse, if1.ps2_clk_oe, if1.ps2_data_oe, if1.frame_err, if1.init_done}, 0);
      end else begin
        since++;
        chk("u0_oe", {if0.ps2_clk_oe, if0.ps2_data_oe}, 0);
        if (since >= 1) chk("u0_init_done", if0.init_done, 1);
        if (if0.frame_err) got_err++;
        chk("err_width", prev_err & if0.frame_err, 0);
        prev_err = if0.frame_err;
        if (if0.ps2_mouse !== last0) begin
          if (exp_q.size() == 0) chk("unexpected_update", if0.ps2_mouse, last0);
          else chk("packet_word", if0.ps2_mouse, exp_q.pop_front());
          last0 = if0.ps2_mouse;
        end
      end
    end
  end

  initial begin : watchdog
    #(10 * 150000);
    $display("FAIL watchdog: got no finish, expected finish within 150000 cycles");
    $fatal(1);
  end

  initial begin : main
    logic [9:0] txe;
    int t, hi;
    #1 reset_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      d_clk[0] = 1'($urandom); d_dat[0] = 1'($urandom);
      d_clk[1] = 1'($urandom); d_dat[1] = 1'($urandom);
    end
    d_clk = '{1'b1, 1'b1};
    d_dat = '{1'b1, 1'b1};
    repeat (4) @(negedge clk);
    #1 reset_n = 1'b1;

    // init handshake on u1
    t = 0;
    while (!if1.ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
    chk("clk_oe_rise_in_time", (t < 100), 1);
    hi = 0;
    while (if1.ps2_clk_oe && hi < 5000) begin @(negedge clk); hi++; end
    chk("inhibit_len", hi, 2400);
    chk("data_oe_at_release", if1.ps2_data_oe, 1);
    repeat (HB) @(negedge clk);
    chk("tx_start_bit", if1.ps2_data_i, 0);
    txe = {1'b1, 1'b0, 8'hF4};
    for (int i = 0; i < 10; i++) begin
      d_clk[1] = 1'b0;
      repeat (HB) @(negedge clk);
      chk($sformatf("tx_bit%0d", i), if1.ps2_data_i, txe[i]);
      d_clk[1] = 1'b1;
      repeat (HB) @(negedge clk);
    end
    d_dat[1] = 1'b0;
    repeat (HB) @(negedge clk);
    d_clk[1] = 1'b0;
    repeat (HB) @(negedge clk);
    d_clk[1] = 1'b1;
    repeat (HB) @(negedge clk);
    d_dat[1] = 1'b1;
    repeat (2 * HB) @(negedge clk);
    chk("init_done_before_fa", if1.init_done, 0);
    send_frame(1, 8'h55, 0, 11, 0);
    chk("init_done_after_55", if1.init_done, 0);
    send_frame(1, 8'hFA, 0, 11, 0);
    chk("init_done_after_fa", if1.init_done, 1);
    chk("u1_mouse_untouched", if1.ps2_mouse, 0);

    // valid packets
    send_pkt(8'h09, 8'h05, 8'hFB);
    checkpoint("pkt1");
    chk("pkt1_word", if0.ps2_mouse, 25'h1FB0509);
    send_pkt(8'h09, 8'h05, 8'hFB);
    checkpoint("pkt2");
    chk("pkt2_word", if0.ps2_mouse, 25'h0FB0509);

    // parity error on the second byte
    send_frame(0, 8'h09, 0, 11, 1);
    send_frame(0, 8'h05, 1, 11, 1);
    checkpoint("par");
    chk("par_no_toggle", if0.ps2_mouse, 25'h0FB0509);
    send_pkt(8'h0A, 8'h01, 8'h02);
    checkpoint("par_next");
    chk("par_next_word", if0.ps2_mouse, 25'h102010A);

    // resync on status bit 3
    send_frame(0, 8'h01, 0, 11, 1);
    send_pkt(8'h08, 8'h10, 8'h20);
    checkpoint("resync");
    chk("resync_word", if0.ps2_mouse, 25'h0201008);

    // partial frame then frame timeout
    send_frame(0, 8'h08, 0, 11, 1);
    send_frame(0, 8'hFF, 0, 5, 0);
    repeat (TMO + 100) @(negedge clk);
    exp_err++;
    m_idx = 0;
    checkpoint("abort");
    send_pkt(8'h28, 8'h33, 8'h44);
    checkpoint("abort_next");
    chk("abort_next_word", if0.ps2_mouse, 25'h1443328);

    // randomized bytes with injected parity/stop errors
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 3; k++) begin
        int r;
        r = $urandom_range(0, 7);
        send_frame(0, 8'($urandom), (r == 0) ? 1 : ((r == 1) ? 2 : 0), 11, 1);
      end
      checkpoint($sformatf("rand%0d", p));
    end

    // reset mid-packet discards the partial packet
    send_frame(0, 8'h18, 0, 11, 1);
    pulse_reset(3);
    send_pkt(8'h18, 8'h22, 8'h33);
    checkpoint("after_reset");
    chk("after_reset_word", if0.ps2_mouse, 25'h1332218);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
